// File: rtl/sd_sector_arbiter_if.sv
// SD sector channel between the arbiter and the user_io SPI block.
// master: arbiter side, slave: user_io side.
interface sd_sector_arbiter_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_dout;
  logic        sd_dout_strobe;
  logic [7:0]  sd_din;
  logic        sd_din_strobe;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_din,
    input  sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_din,
    output sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
  );
endinterface

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one SD sector channel among NREQ requesters.
// Synchronises SPI-domain ack/strobes, routes bytes, and aborts stuck
// transfers with a watchdog.
module sd_sector_arbiter #(
  parameter int          NREQ    = 2,
  parameter logic [23:0] TIMEOUT = 24'd12000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_lba,
  input  logic [8*NREQ-1:0]    req_din,
  output logic [NREQ-1:0]      req_ack,
  output logic [7:0]           req_dout,
  output logic [NREQ-1:0]      req_dout_strobe,
  output logic [NREQ-1:0]      req_din_strobe,
  output logic [NREQ-1:0]      req_err,
  output logic [1:0]           grant,
  output logic                 busy,
  sd_sector_arbiter_if.master  sd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Requester inputs widened to 4 slots; absent slots read as idle.
  logic [3:0]       rd4, wr4;
  logic [3:0][31:0] lba4;
  logic [3:0][7:0]  din4;

  for (genvar i = 0; i < 4; i++) begin : g_map
    if (i < NREQ) begin : g_on
      assign rd4[i]  = req_rd[i];
      assign wr4[i]  = req_wr[i];
      assign lba4[i] = req_lba[32*i +: 32];
      assign din4[i] = req_din[8*i +: 8];
    end else begin : g_off
      assign rd4[i]  = 1'b0;
      assign wr4[i]  = 1'b0;
      assign lba4[i] = '0;
      assign din4[i] = '0;
    end
  end

  // SPI-domain synchronisers and rising-edge detectors.
  logic [1:0] ack_ff_q, dst_ff_q, ist_ff_q;
  logic       dst_prev_q, ist_prev_q;
  logic       dout_p_q, din_p_q;
  logic       ack_s;

  // 2-FF synchronisers plus registered edge pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_ff_q   <= '0;
      dst_ff_q   <= '0;
      ist_ff_q   <= '0;
      dst_prev_q <= 1'b0;
      ist_prev_q <= 1'b0;
      dout_p_q   <= 1'b0;
      din_p_q    <= 1'b0;
    end else begin
      ack_ff_q   <= {ack_ff_q[0], sd.sd_ack};
      dst_ff_q   <= {dst_ff_q[0], sd.sd_dout_strobe};
      ist_ff_q   <= {ist_ff_q[0], sd.sd_din_strobe};
      dst_prev_q <= dst_ff_q[1];
      ist_prev_q <= ist_ff_q[1];
      dout_p_q   <= dst_ff_q[1] & ~dst_prev_q;
      din_p_q    <= ist_ff_q[1] & ~ist_prev_q;
    end
  end

  assign ack_s = ack_ff_q[1];

  logic [1:0]      state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [31:0]     lba_q, lba_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      dout_q, dout_d;
  logic [NREQ-1:0] dstb_q, dstb_d, istb_q, istb_d, err_q, err_d;
  logic [23:0]     wdog_q, wdog_d;

  logic [3:0]      oh4;
  logic [NREQ-1:0] gnt_oh;
  logic [3:0]      req4;
  logic            found;
  logic [1:0]      win;
  logic [2:0]      sum;
  logic            expired;

  assign oh4     = 4'b0001 << grant_q;
  assign gnt_oh  = oh4[NREQ-1:0];
  assign req4    = rd4 | wr4;
  assign expired = (wdog_q == TIMEOUT - 24'd1);

  // Round-robin search starting one past the last grant.
  always_comb begin
    found = 1'b0;
    win   = grant_q;
    sum   = 3'd0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = 3'(grant_q) + 3'(k);
      if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
      if (!found && req4[sum[1:0]]) begin
        found = 1'b1;
        win   = sum[1:0];
      end
    end
  end

  // Transfer FSM; watchdog abort takes precedence over a same-cycle ack.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    dstb_d  = '0;
    istb_d  = '0;
    err_d   = '0;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (!ack_s && found) begin
          grant_d = win;
          lba_d   = lba4[win];
          rd_d    = rd4[win];
          wr_d    = wr4[win] & ~rd4[win];
          wdog_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE, S_XFER: begin
        wdog_d = wdog_q + 24'd1;
        if (expired) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = '0;
          err_d   = gnt_oh;
          state_d = S_DRAIN;
        end else if (state_q == S_ISSUE) begin
          if (ack_s) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            ack_d   = gnt_oh;
            state_d = S_XFER;
          end
        end else begin
          if (dout_p_q) begin
            dout_d = sd.sd_dout;
            dstb_d = gnt_oh;
          end
          if (din_p_q) istb_d = gnt_oh;
          if (!ack_s) begin
            ack_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        // Hold until the host lets go of ack so it is not credited onward.
        if (!ack_s) state_d = S_IDLE;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
      dout_q  <= '0;
      dstb_q  <= '0;
      istb_q  <= '0;
      err_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      dstb_q  <= dstb_d;
      istb_q  <= istb_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign req_ack         = ack_q;
  assign req_dout        = dout_q;
  assign req_dout_strobe = dstb_q;
  assign req_din_strobe  = istb_q;
  assign req_err         = err_q;
  assign grant           = grant_q;
  assign busy            = (state_q != S_IDLE);
  assign sd.sd_lba       = lba_q;
  assign sd.sd_rd        = rd_q;
  assign sd.sd_wr        = wr_q;
  assign sd.sd_din       = din4[grant_q];

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter: read stream, arbitration order,
// write byte stepping, watchdog abort with late ack, mid-transfer reset.
module tb_sd_sector_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  req_rd, req_wr, wd_rd, wd_wr;
  logic [63:0] req_lba;
  logic [15:0] req_din;

  logic [1:0]  ack, dstb, istb, err, grant;
  logic [7:0]  dout;
  logic        busy;
  logic [1:0]  w_ack, w_dstb, w_istb, w_err, w_grant;
  logic [7:0]  w_dout;
  logic        w_busy;

  sd_sector_arbiter_if sd ();
  sd_sector_arbiter_if wsd ();

  sd_sector_arbiter #(.NREQ(2), .TIMEOUT(24'd20000)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_din(req_din),
    .req_ack(ack), .req_dout(dout), .req_dout_strobe(dstb),
    .req_din_strobe(istb), .req_err(err), .grant(grant), .busy(busy),
    .sd(sd.master)
  );

  sd_sector_arbiter #(.NREQ(2), .TIMEOUT(24'd100)) u_wd (
    .clk(clk), .reset_n(reset_n),
    .req_rd(wd_rd), .req_wr(wd_wr), .req_lba(req_lba), .req_din(req_din),
    .req_ack(w_ack), .req_dout(w_dout), .req_dout_strobe(w_dstb),
    .req_din_strobe(w_istb), .req_err(w_err), .grant(w_grant), .busy(w_busy),
    .sd(wsd.master)
  );

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0;
  logic mon_en = 1'b0;
  logic [9:0] sbq[$];
  logic [9:0] e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every forwarded read byte must match the next queued one.
  always @(negedge clk) begin
    if (mon_en && dstb !== 2'b00) begin
      if (sbq.size() == 0) begin
        chk("dout_unexpected", 32'(dstb), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("dout_strobe_dst", 32'(dstb), (e[9:8] == 2'd0) ? 32'd1 : 32'd2);
        chk("dout_byte", 32'(dout), 32'(e[7:0]));
        rx_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic got;
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; wd_rd = '0; wd_wr = '0;
    req_lba = {32'h0000_5678, 32'h0000_1234};
    req_din = {8'hA0, 8'h11};
    sd.sd_ack = 1'b0; sd.sd_dout = '0; sd.sd_dout_strobe = 1'b0; sd.sd_din_strobe = 1'b0;
    wsd.sd_ack = 1'b0; wsd.sd_dout = '0; wsd.sd_dout_strobe = 1'b0; wsd.sd_din_strobe = 1'b0;
    tick(3);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Reset state
    chk("rst_sd_rd", 32'(sd.sd_rd), 32'd0);
    chk("rst_sd_wr", 32'(sd.sd_wr), 32'd0);
    chk("rst_sd_lba", sd.sd_lba, 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_pulses", 32'({dstb, istb, err}), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wd_busy", 32'(w_busy), 32'd0);

    // Read of 512 bytes on requester 0
    req_rd = 2'b01;
    tick(1);
    chk("t1_sd_rd", 32'(sd.sd_rd), 32'd1);
    chk("t1_lba", sd.sd_lba, 32'h0000_1234);
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(10);
    chk("t1_rd_held", 32'(sd.sd_rd), 32'd1);
    sd.sd_ack = 1'b1;
    tick(2);
    chk("t1_rd_before_ack", 32'(sd.sd_rd), 32'd1);
    chk("t1_ack_not_yet", 32'(ack), 32'd0);
    tick(1);
    chk("t1_rd_cleared", 32'(sd.sd_rd), 32'd0);
    chk("t1_ack_set", 32'(ack), 32'd1);
    req_rd = 2'b00;
    for (int i = 0; i < 512; i++) begin
      sd.sd_dout = 8'(i);
      sbq.push_back({2'd0, 8'(i)});
      sd.sd_dout_strobe = 1'b1;
      tick(4);
      sd.sd_dout_strobe = 1'b0;
      tick(4);
    end
    tick(4);
    chk("t1_rx_count", 32'(rx_cnt), 32'd512);
    chk("t1_sb_empty", 32'(sbq.size()), 32'd0);
    chk("t1_ack_still", 32'(ack), 32'd1);
    sd.sd_ack = 1'b0;
    tick(2);
    chk("t1_ack_before_fall", 32'(ack), 32'd1);
    tick(1);
    chk("t1_ack_fall", 32'(ack), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Simultaneous requests after reset: requester 1 first
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    req_rd = 2'b01; req_wr = 2'b10;
    tick(1);
    chk("t2_grant1", 32'(grant), 32'd1);
    chk("t2_sd_wr", 32'(sd.sd_wr), 32'd1);
    chk("t2_sd_rd", 32'(sd.sd_rd), 32'd0);
    chk("t2_lba1", sd.sd_lba, 32'h0000_5678);
    chk("t2_din_first", 32'(sd.sd_din), 32'hA0);
    sd.sd_ack = 1'b1;
    tick(3);
    chk("t2_ack1", 32'(ack), 32'd2);
    req_wr = 2'b00;

    // Write bytes stepping per req_din_strobe[1]
    for (int i = 0; i < 3; i++) begin
      sd.sd_din_strobe = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        tick(1);
        if (istb !== 2'b00) begin
          got = 1'b1;
          chk("t3_din_strobe_dst", 32'(istb), 32'd2);
        end
      end
      chk("t3_din_strobe_seen", 32'(got), 32'd1);
      tick(1);
      chk("t3_din_strobe_width", 32'(istb), 32'd0);
      req_din[15:8] = 8'(8'hA1 + i);
      tick(1);
      chk("t3_sd_din", 32'(sd.sd_din), 32'(8'hA1 + i));
      sd.sd_din_strobe = 1'b0;
      tick(4);
    end
    sd.sd_ack = 1'b0;
    tick(2);
    chk("t2_ack1_hold", 32'(ack), 32'd2);
    tick(1);
    chk("t2_ack1_fall", 32'(ack), 32'd0);
    tick(1);
    chk("t2_grant0_next", 32'(grant), 32'd0);
    chk("t2_sd_rd0", 32'(sd.sd_rd), 32'd1);
    chk("t2_lba0", sd.sd_lba, 32'h0000_1234);
    sd.sd_ack = 1'b1;
    tick(3);
    chk("t2_ack0", 32'(ack), 32'd1);
    req_rd = 2'b00;
    sd.sd_ack = 1'b0;
    tick(4);
    chk("t2_idle", 32'(busy), 32'd0);

    // Read and write both set on requester 0, then reset mid-transfer
    req_rd = 2'b01; req_wr = 2'b01;
    tick(1);
    chk("t4_both_rd", 32'(sd.sd_rd), 32'd1);
    chk("t4_both_wr", 32'(sd.sd_wr), 32'd0);
    chk("t4_grant", 32'(grant), 32'd0);
    sd.sd_ack = 1'b1;
    tick(3);
    chk("t4_ack", 32'(ack), 32'd1);
    req_rd = 2'b00; req_wr = 2'b00;
    sd.sd_dout = 8'h5A;
    sd.sd_dout_strobe = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    chk("t5_rst_ack", 32'(ack), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_lba", sd.sd_lba, 32'd0);
    chk("t5_rst_rdwr", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t5_no_pulses", 32'({dstb, istb, err}), 32'd0);
    end
    sd.sd_dout_strobe = 1'b0;
    sd.sd_ack = 1'b0;
    tick(4);
    chk("t5_idle", 32'(busy), 32'd0);

    // Watchdog (TIMEOUT=100) with host ack arriving in the expiry cycle
    wd_rd = 2'b01;
    tick(1);
    chk("t6_rd", 32'(wsd.sd_rd), 32'd1);
    chk("t6_grant", 32'(w_grant), 32'd0);
    tick(97);
    wsd.sd_ack = 1'b1;
    tick(2);
    chk("t6_rd_at_99", 32'(wsd.sd_rd), 32'd1);
    chk("t6_err_at_99", 32'(w_err), 32'd0);
    tick(1);
    chk("t6_rd_abort", 32'(wsd.sd_rd), 32'd0);
    chk("t6_err_pulse", 32'(w_err), 32'd1);
    chk("t6_no_ack", 32'(w_ack), 32'd0);
    chk("t6_busy_drain", 32'(w_busy), 32'd1);
    wd_rd = 2'b10;
    tick(5);
    chk("t6_drain_busy", 32'(w_busy), 32'd1);
    chk("t6_drain_ack", 32'(w_ack), 32'd0);
    chk("t6_drain_grant", 32'(w_grant), 32'd0);
    chk("t6_err_width", 32'(w_err), 32'd0);
    chk("t6_drain_rd", 32'(wsd.sd_rd), 32'd0);
    wsd.sd_ack = 1'b0;
    tick(3);
    chk("t6_idle", 32'(w_busy), 32'd0);
    tick(1);
    chk("t6_regrant", 32'(w_grant), 32'd1);
    chk("t6_regrant_rd", 32'(wsd.sd_rd), 32'd1);
    wd_rd = 2'b00;
    wsd.sd_ack = 1'b1;
    tick(3);
    chk("t6_ack1", 32'(w_ack), 32'd2);
    wsd.sd_ack = 1'b0;
    tick(4);
    chk("t6_end_idle", 32'(w_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
